// File: rtl/dc_mem_responder.sv
// dc_mem_responder: memory-side responder for the data cache.
// Turns dirty-line evictions, line fills and single-word IO accesses into
// sequences of 32-bit beats on a word-wide backing bus, then returns a
// one-cycle completion pulse to the cache. Every output is a register.
module dc_mem_responder #(
  parameter int C_LINE_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  // cache miss / evict request
  input  logic                dc_miss,
  input  logic [31:0]         dc_miss_addr,
  input  logic                dc_evict,
  input  logic [31:0]         dc_evict_addr,
  input  logic [C_LINE_W-1:0] dc_evict_data,
  output logic [C_LINE_W-1:0] dc_data_fill,
  output logic                dc_miss_ack,
  // uncached IO request
  input  logic                io_access,
  input  logic                io_rw,
  input  logic [31:0]         io_addr,
  input  logic [31:0]         io_wr_data,
  output logic [31:0]         io_rd_data,
  output logic                io_ack,
  // backing bus
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_io,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack
);

  localparam int NWORDS = C_LINE_W / 32;

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL, S_MACK, S_IO, S_IOACK, S_HOLD
  } state_t;

  state_t              r_state, w_state;
  logic [1:0]          r_cnt, w_cnt;
  logic [1:0]          w_cnt_inc;
  logic [31:0]         r_miss_addr, w_miss_addr;
  logic [31:0]         r_evict_addr, w_evict_addr;
  logic [C_LINE_W-1:0] r_evict_data, w_evict_data;
  logic                r_io_rw, w_io_rw;
  logic [31:0]         r_fill_word [NWORDS];
  logic [31:0]         w_fill_word [NWORDS];
  logic [31:0]         r_io_rd_data, w_io_rd_data;
  logic                r_miss_ack, w_miss_ack;
  logic                r_io_ack, w_io_ack;
  logic                r_mem_req, w_mem_req;
  logic                r_mem_we, w_mem_we;
  logic                r_mem_io, w_mem_io;
  logic [31:0]         r_mem_addr, w_mem_addr;
  logic [31:0]         r_mem_wdata, w_mem_wdata;
  logic [31:0]         w_evict_word [NWORDS];
  logic                w_beat_done;

  // Split the latched victim line into words and pack fill words onto the port.
  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_words
      assign w_evict_word[gi]           = r_evict_data[32*gi +: 32];
      assign dc_data_fill[32*gi +: 32]  = r_fill_word[gi];
    end
  endgenerate

  assign w_cnt_inc   = r_cnt + 2'd1;
  assign w_beat_done = r_mem_req & mem_ack;

  assign dc_miss_ack = r_miss_ack;
  assign io_rd_data  = r_io_rd_data;
  assign io_ack      = r_io_ack;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_io      = r_mem_io;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

  // Next-state and next-output logic; bus outputs are computed one cycle
  // ahead so the registered beat appears right after the deciding edge.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_miss_addr  = r_miss_addr;
    w_evict_addr = r_evict_addr;
    w_evict_data = r_evict_data;
    w_io_rw      = r_io_rw;
    w_fill_word  = r_fill_word;
    w_io_rd_data = r_io_rd_data;
    w_miss_ack   = 1'b0;
    w_io_ack     = 1'b0;
    w_mem_req    = r_mem_req;
    w_mem_we     = r_mem_we;
    w_mem_io     = r_mem_io;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;

    case (r_state)
      S_IDLE: begin
        if (dc_miss && dc_evict) begin
          w_miss_addr  = dc_miss_addr;
          w_evict_addr = dc_evict_addr;
          w_evict_data = dc_evict_data;
          w_cnt        = 2'd0;
          w_state      = S_WB;
          w_mem_req    = 1'b1;
          w_mem_we     = 1'b1;
          w_mem_io     = 1'b0;
          w_mem_addr   = dc_evict_addr;
          w_mem_wdata  = dc_evict_data[31:0];
        end else if (dc_miss) begin
          w_miss_addr  = dc_miss_addr;
          w_cnt        = 2'd0;
          w_state      = S_FILL;
          w_mem_req    = 1'b1;
          w_mem_we     = 1'b0;
          w_mem_io     = 1'b0;
          w_mem_addr   = dc_miss_addr;
          w_mem_wdata  = 32'd0;
        end else if (io_access) begin
          w_io_rw      = io_rw;
          w_state      = S_IO;
          w_mem_req    = 1'b1;
          w_mem_we     = io_rw;
          w_mem_io     = 1'b1;
          w_mem_addr   = io_addr;
          w_mem_wdata  = io_wr_data;
        end
      end

      S_WB: begin
        if (w_beat_done) begin
          if (r_cnt == 2'd3) begin
            // Victim fully written; the fill starts with no bubble.
            w_cnt       = 2'd0;
            w_state     = S_FILL;
            w_mem_we    = 1'b0;
            w_mem_addr  = r_miss_addr;
            w_mem_wdata = 32'd0;
          end else begin
            w_cnt       = w_cnt_inc;
            w_mem_addr  = r_evict_addr + {28'd0, w_cnt_inc, 2'b00};
            w_mem_wdata = w_evict_word[w_cnt_inc];
          end
        end
      end

      S_FILL: begin
        if (w_beat_done) begin
          w_fill_word[r_cnt] = mem_rdata;
          if (r_cnt == 2'd3) begin
            w_cnt       = 2'd0;
            w_state     = S_MACK;
            w_miss_ack  = 1'b1;
            w_mem_req   = 1'b0;
            w_mem_we    = 1'b0;
            w_mem_io    = 1'b0;
            w_mem_addr  = 32'd0;
            w_mem_wdata = 32'd0;
          end else begin
            w_cnt      = w_cnt_inc;
            w_mem_addr = r_miss_addr + {28'd0, w_cnt_inc, 2'b00};
          end
        end
      end

      S_MACK:  w_state = S_HOLD;

      S_IO: begin
        if (w_beat_done) begin
          // Writes leave the last read value visible.
          if (!r_io_rw) w_io_rd_data = mem_rdata;
          w_state     = S_IOACK;
          w_io_ack    = 1'b1;
          w_mem_req   = 1'b0;
          w_mem_we    = 1'b0;
          w_mem_io    = 1'b0;
          w_mem_addr  = 32'd0;
          w_mem_wdata = 32'd0;
        end
      end

      S_IOACK: w_state = S_HOLD;

      // One dead cycle so a request still held after its ack is not re-serviced.
      S_HOLD:  w_state = S_IDLE;

      default: w_state = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_miss_addr  <= 32'd0;
      r_evict_addr <= 32'd0;
      r_evict_data <= '0;
      r_io_rw      <= 1'b0;
      r_fill_word  <= '{default: 32'd0};
      r_io_rd_data <= 32'd0;
      r_miss_ack   <= 1'b0;
      r_io_ack     <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_io     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_miss_addr  <= w_miss_addr;
      r_evict_addr <= w_evict_addr;
      r_evict_data <= w_evict_data;
      r_io_rw      <= w_io_rw;
      r_fill_word  <= w_fill_word;
      r_io_rd_data <= w_io_rd_data;
      r_miss_ack   <= w_miss_ack;
      r_io_ack     <= w_io_ack;
      r_mem_req    <= w_mem_req;
      r_mem_we     <= w_mem_we;
      r_mem_io     <= w_mem_io;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
    end
  end

endmodule

// File: tb/tb_dc_mem_responder.sv
// Testbench for dc_mem_responder: cycle-by-cycle vector table covering a
// zero-wait miss, evict+miss, a wait-stated IO read and an IO write with a
// miss held through HOLD, then a hand-written reset-during-writeback check.
module tb_dc_mem_responder;

  logic         clk;
  logic         rst_n;
  logic         dc_miss;
  logic [31:0]  dc_miss_addr;
  logic         dc_evict;
  logic [31:0]  dc_evict_addr;
  logic [127:0] dc_evict_data;
  logic [127:0] dc_data_fill;
  logic         dc_miss_ack;
  logic         io_access;
  logic         io_rw;
  logic [31:0]  io_addr;
  logic [31:0]  io_wr_data;
  logic [31:0]  io_rd_data;
  logic         io_ack;
  logic         mem_req;
  logic         mem_we;
  logic         mem_io;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ack;

  dc_mem_responder #(.C_LINE_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
    .dc_evict(dc_evict), .dc_evict_addr(dc_evict_addr), .dc_evict_data(dc_evict_data),
    .dc_data_fill(dc_data_fill), .dc_miss_ack(dc_miss_ack),
    .io_access(io_access), .io_rw(io_rw), .io_addr(io_addr), .io_wr_data(io_wr_data),
    .io_rd_data(io_rd_data), .io_ack(io_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         miss, evict, io, rw;
    logic [31:0]  ioa, iowd;
    logic         ack;
    logic [31:0]  rdata;
    logic         req, we, mio;
    logic [31:0]  addr, wdata;
    logic         mack, iack;
    logic [31:0]  rd;
    logic [127:0] fill;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [127:0] F_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] F_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] F_E = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
  localparam logic [127:0] F_R = {32'hC0C0200C, 32'hC0C02008, 32'hC0C02004, 32'hC0C02000};
  localparam logic [31:0]  BAD = 32'h0BAD0BAD;
  localparam logic [31:0]  DB  = 32'hDEADBEEF;

  function automatic vec_t mk(
    input logic miss, input logic evict, input logic io, input logic rw,
    input logic [31:0] ioa, input logic [31:0] iowd,
    input logic ack, input logic [31:0] rdata,
    input logic req, input logic we, input logic mio,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic mack, input logic iack, input logic [31:0] rd, input logic [127:0] fill);
    vec_t v;
    v.miss = miss; v.evict = evict; v.io = io; v.rw = rw;
    v.ioa = ioa; v.iowd = iowd; v.ack = ack; v.rdata = rdata;
    v.req = req; v.we = we; v.mio = mio; v.addr = addr; v.wdata = wdata;
    v.mack = mack; v.iack = iack; v.rd = rd; v.fill = fill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // Zero-wait miss at 0x1230: beats complete at edges 1..4, ack after edge 4.
    tbl.push_back(mk(1,0,0,0, 0,0, 1,0,     1,0,0,32'h1230,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,32'hA0, 1,0,0,32'h1234,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,32'hA1, 1,0,0,32'h1238,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,32'hA2, 1,0,0,32'h123C,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,32'hA3, 0,0,0,0,0,        1,0,0,F_A));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,0,     0,0,0,0,0,        0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,0,     0,0,0,0,0,        0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 1,0,     0,0,0,0,0,        0,0,0,0));
    // Evict 0x0560 (0x11..0x44) then fill 0x1230, ack after edge 8.
    tbl.push_back(mk(1,1,0,0, 0,0, 1,BAD,    1,1,0,32'h0560,32'h11, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,BAD,    1,1,0,32'h0564,32'h22, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,BAD,    1,1,0,32'h0568,32'h33, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,BAD,    1,1,0,32'h056C,32'h44, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,BAD,    1,0,0,32'h1230,0,      0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,32'hB0, 1,0,0,32'h1234,0,      0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,32'hB1, 1,0,0,32'h1238,0,      0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,32'hB2, 1,0,0,32'h123C,0,      0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,32'hB3, 0,0,0,0,0,             1,0,0,F_B));
    tbl.push_back(mk(0,0,0,0, 0,0, 1,0,      0,0,0,0,0,             0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 1,0,      0,0,0,0,0,             0,0,0,0));
    // IO read 0x8004 with three wait cycles, then held through ack and HOLD.
    tbl.push_back(mk(0,0,1,0, 32'h8004,0, 0,BAD, 1,0,1,32'h8004,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 32'h8004,0, 0,BAD, 1,0,1,32'h8004,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 32'h8004,0, 0,BAD, 1,0,1,32'h8004,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 32'h8004,0, 0,BAD, 1,0,1,32'h8004,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 32'h8004,0, 1,DB,  0,0,0,0,0,        0,1,DB,0));
    tbl.push_back(mk(0,0,1,0, 32'h8004,0, 1,BAD, 0,0,0,0,0,        0,0,DB,0));
    tbl.push_back(mk(0,0,1,0, 32'h8004,0, 1,BAD, 0,0,0,0,0,        0,0,DB,0));
    tbl.push_back(mk(0,0,0,0, 32'h8004,0, 1,BAD, 0,0,0,0,0,        0,0,DB,0));
    // IO write 0x8000 with dc_miss raised mid-transaction and held through HOLD.
    tbl.push_back(mk(0,0,1,1, 32'h8000,32'h5A5A5A5A, 1,BAD,          1,1,1,32'h8000,32'h5A5A5A5A, 0,0,DB,0));
    tbl.push_back(mk(1,0,1,1, 32'h8000,32'h5A5A5A5A, 1,32'h12345678, 0,0,0,0,0, 0,1,DB,0));
    tbl.push_back(mk(1,0,1,1, 32'h8000,32'h5A5A5A5A, 1,BAD,          0,0,0,0,0, 0,0,DB,0));
    tbl.push_back(mk(1,0,1,1, 32'h8000,32'h5A5A5A5A, 1,BAD,          0,0,0,0,0, 0,0,DB,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,BAD,    1,0,0,32'h1230,0, 0,0,DB,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,32'hE0, 1,0,0,32'h1234,0, 0,0,DB,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,32'hE1, 1,0,0,32'h1238,0, 0,0,DB,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,32'hE2, 1,0,0,32'h123C,0, 0,0,DB,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,32'hE3, 0,0,0,0,0,        1,0,DB,F_E));
    tbl.push_back(mk(0,0,0,0, 0,0, 1,0,      0,0,0,0,0,        0,0,DB,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 1,0,      0,0,0,0,0,        0,0,DB,0));
  end

  initial begin
    int got;
    rst_n = 1'b0; dc_miss = 1'b0; dc_evict = 1'b0; io_access = 1'b0; io_rw = 1'b0;
    dc_miss_addr = 32'h1230; dc_evict_addr = 32'h0560;
    dc_evict_data = {32'h44, 32'h33, 32'h22, 32'h11};
    io_addr = 32'd0; io_wr_data = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_req", mem_req, 0);
    chk("reset dc_miss_ack", dc_miss_ack, 0);
    chk("reset io_ack", io_ack, 0);
    chk("reset dc_data_fill", dc_data_fill, 0);
    chk("reset io_rd_data", io_rd_data, 0);
    chk("reset mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      dc_miss = tbl[i].miss; dc_evict = tbl[i].evict;
      io_access = tbl[i].io; io_rw = tbl[i].rw;
      io_addr = tbl[i].ioa; io_wr_data = tbl[i].iowd;
      mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
      @(posedge clk);
      #1;
      $display("%s miss=%b ev=%b io=%b ack=%b -> req=%b we=%b io=%b addr=%h wd=%h mack=%b iack=%b rd=%h",
               tag, tbl[i].miss, tbl[i].evict, tbl[i].io, tbl[i].ack,
               mem_req, mem_we, mem_io, mem_addr, mem_wdata, dc_miss_ack, io_ack, io_rd_data);
      chk({tag, " mem_req"}, mem_req, tbl[i].req);
      chk({tag, " dc_miss_ack"}, dc_miss_ack, tbl[i].mack);
      chk({tag, " io_ack"}, io_ack, tbl[i].iack);
      chk({tag, " io_rd_data"}, io_rd_data, tbl[i].rd);
      if (tbl[i].req) begin
        chk({tag, " mem_we"}, mem_we, tbl[i].we);
        chk({tag, " mem_io"}, mem_io, tbl[i].mio);
        chk({tag, " mem_addr"}, mem_addr, tbl[i].addr);
        if (tbl[i].we) chk({tag, " mem_wdata"}, mem_wdata, tbl[i].wdata);
      end
      if (tbl[i].mack) chk({tag, " dc_data_fill"}, dc_data_fill, tbl[i].fill);
    end

    // Reset asserted while WB beat 2 is on the bus.
    mem_ack = 1'b1; dc_miss = 1'b1; dc_evict = 1'b1; io_access = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("wb beat2 in flight: addr=%h wdata=%h", mem_addr, mem_wdata);
    chk("wb beat2 mem_addr", mem_addr, 32'h0568);
    chk("wb beat2 mem_wdata", mem_wdata, 32'h33);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    $display("after reset: req=%b we=%b io=%b addr=%h fill=%h rd=%h",
             mem_req, mem_we, mem_io, mem_addr, dc_data_fill, io_rd_data);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_io", mem_io, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst dc_miss_ack", dc_miss_ack, 0);
    chk("rst io_ack", io_ack, 0);
    chk("rst dc_data_fill", dc_data_fill, 0);
    chk("rst io_rd_data", io_rd_data, 0);
    rst_n = 1'b1; dc_miss = 1'b0; dc_evict = 1'b0;
    @(posedge clk);
    #1;

    // Fresh miss after reset: ack must appear 5 cycles after the request is sampled.
    dc_miss_addr = 32'h2000; dc_miss = 1'b1;
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      mem_rdata = mem_addr ^ 32'hC0C00000;
      @(posedge clk);
      #1;
      if (dc_miss_ack) begin
        got = c;
        break;
      end
    end
    $display("fresh miss: ack after %0d cycles, fill=%h", got, dc_data_fill);
    chk("fresh miss latency", got, 5);
    chk("fresh miss fill", dc_data_fill, F_R);
    dc_miss = 1'b0;
    @(posedge clk);
    #1;
    chk("fresh miss ack one cycle", dc_miss_ack, 0);
    chk("fill held after ack", dc_data_fill, F_R);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dc_mem_responder.md
# dc_mem_responder

Memory-side responder for the data cache's miss, evict and uncached-IO request interface. It accepts dirty-line evictions, line fills and single-word IO accesses from `dcache`. Each request becomes a sequence of 32-bit beats on a word-wide backing bus. Completion is returned as a one-cycle `dc_miss_ack` with `dc_data_fill`, or as a one-cycle `io_ack` with `io_rd_data`. It sits in the MMU between `dcache` and the system memory/IO bus.

## Interface
- C_LINE_W, 128, cache line width in bits; only 128 (4 words) is supported
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- dc_miss  in  1  line-fill request, held until `dc_miss_ack`
- dc_miss_addr  in  32  line-aligned fill address (bits [3:0] = 0)
- dc_evict  in  1  dirty victim writeback; only ever asserted together with `dc_miss`
- dc_evict_addr  in  32  line-aligned victim address
- dc_evict_data  in  128  victim line, word k = bits [32k+31:32k]
- dc_data_fill  out  128  fill line, valid while `dc_miss_ack`=1, held until next fill
- dc_miss_ack  out  1  one-cycle completion pulse for miss (and evict if present)
- io_access  in  1  uncached access request, held until `io_ack`
- io_rw  in  1  1 = write, 0 = read
- io_addr  in  32  word-aligned IO address
- io_wr_data  in  32  IO write data
- io_rd_data  out  32  IO read data, valid while `io_ack`=1, held until next IO read completes
- io_ack  out  1  one-cycle IO completion pulse
- mem_req  out  1  bus beat request
- mem_we  out  1  1 = write beat
- mem_io  out  1  1 = uncached IO beat, 0 = cacheable line beat
- mem_addr  out  32  beat address
- mem_wdata  out  32  beat write data
- mem_rdata  in  32  read data; sampled on the edge that completes a read beat
- mem_ack  in  1  a beat completes on every rising edge where `mem_req`=1 and `mem_ack`=1

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE, beat counter 0, all outputs 0 including `dc_data_fill` and `io_rd_data`. An in-flight transaction is abandoned; a partially written line in memory is acceptable.
- The FSM has seven states: IDLE, WB, FILL, MACK, IO, IOACK, HOLD.
- IDLE priority is evict > miss > io.
  - `dc_miss`&`dc_evict` → latch miss address, evict address and evict data; go to WB.
  - `dc_miss` alone → latch miss address; go to FILL.
  - `io_access` → latch `io_rw`, `io_addr` and `io_wr_data`; go to IO.
- WB: four write beats with `mem_we`=1 and `mem_io`=0.
  - Beat k drives `mem_addr` = evict_addr + 4k and `mem_wdata` = word k.
  - After beat 3 completes, reset the counter and go to FILL.
- FILL: four read beats with `mem_we`=0 at miss_addr + 4k. The read data of beat k goes into fill word k. After beat 3, go to MACK.
- MACK: `dc_miss_ack`=1 for exactly one cycle with `dc_data_fill` stable; then go to HOLD.
- IO: one beat with `mem_io`=1, `mem_we` = latched rw, and the latched address and write data.
  - On completion, a read captures `mem_rdata` into `io_rd_data`; a write leaves `io_rd_data` unchanged.
  - Then go to IOACK.
- IOACK: `io_ack`=1 for one cycle; then go to HOLD.
- HOLD: one cycle in which all requests are ignored, so a request still visible the cycle after an ack is never re-serviced; then go to IDLE.
- Address, data and `io_rw` are latched only in IDLE; input changes mid-transaction are ignored.
- If `dc_miss`/`io_access` deasserts mid-transaction, the transaction still completes and the ack is still pulsed.
- `mem_req` is held high with stable `mem_addr`/`mem_we`/`mem_wdata`/`mem_io` until the beat completes. The next beat may start the following cycle with no bubble.
- The counter is 2 bits and wraps from 3 to 0 at the end of each line phase.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Zero-wait bus (`mem_ack` always 1), miss only:
  - request seen in IDLE at edge 0
  - FILL beats complete at edges 1–4
  - `dc_miss_ack` high during cycle 5
  - HOLD during cycle 6; IDLE again from cycle 7
  - Total: 5 cycles from first sampled request to ack.
- Miss with evict: 4 more cycles (ack in cycle 9).
- IO: ack in cycle 2.
- Each wait cycle inserted by `mem_ack`=0 adds exactly one cycle to the transaction.
- Back-to-back requests: the next request is sampled no earlier than the first IDLE cycle after HOLD.
- `dc_miss`, `dc_evict` and `io_access` asserted together → evict+miss is serviced first; the IO request is serviced after HOLD if still asserted.

## Test plan
- Zero-wait miss, addr 0x1230, bus returns words 0xA0..0xA3 → beats at 0x1230/4/8/C, `dc_data_fill`=0xA3A2A1A0-packed, `dc_miss_ack` one cycle at cycle 5.
- Evict 0x0560 with data words 0x11..0x44 plus miss 0x1230 → 4 writes at 0x0560..0x056C carrying 0x11,0x22,0x33,0x44, then 4 reads at 0x1230..0x123C, ack at cycle 9.
- IO read 0x8004 with `mem_ack` delayed 3 cycles, rdata 0xDEADBEEF → `mem_io`=1 and `mem_req` held stable 4 cycles, `io_ack` one cycle with `io_rd_data`=0xDEADBEEF, value retained afterwards.
- IO write 0x8000 data 0x5A5A5A5A, `dc_miss` held high through HOLD → exactly one write beat, single `io_ack`, then the miss is serviced only after HOLD; no duplicate service.
- `rst_n`=0 during WB beat 2 → next cycle all outputs 0, state IDLE; a fresh miss afterwards completes normally in 5 cycles.
